// File: rtl/fm_remap_sequencer_pkg.sv
// Shared types and limits for the feature-map remap sequencer.
package fm_remap_sequencer_pkg;

    localparam int MAX_UP_LOG2 = 2;

    typedef enum logic {
        MODE_UPSAMPLE = 1'b0,
        MODE_ROUTE    = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Route copies pixels 1:1, so the exponent is forced to zero there.
    function automatic logic [1:0] eff_up_log2(input logic mode, input logic [1:0] up_log2);
        if (mode_e'(mode) == MODE_ROUTE) return 2'd0;
        if (up_log2 > 2'(MAX_UP_LOG2)) return 2'(MAX_UP_LOG2);
        return up_log2;
    endfunction

endpackage

// File: rtl/fm_remap_sequencer_if.sv
// FM-buffer side of the remap sequencer: read address stream, paired write stream, status.
interface fm_remap_sequencer_if #(
    parameter int FM_AW = 16
);
    logic             rd_vld;
    logic             rd_rdy;
    logic [FM_AW-1:0] rd_addr;
    logic             wr_vld;
    logic [FM_AW-1:0] wr_addr;
    logic             busy;
    logic             done;

    modport master (
        output rd_vld, rd_addr, wr_vld, wr_addr, busy, done,
        input  rd_rdy
    );

    modport slave (
        input  rd_vld, rd_addr, wr_vld, wr_addr, busy, done,
        output rd_rdy
    );
endinterface

// File: rtl/fm_remap_sequencer_counter.sv
// Channel / output-column / output-row walk with wrap and repeat-boundary flags.
module fm_nested_counter
    import fm_remap_sequencer_pkg::*;
#(
    parameter int W_CHN = 8,
    parameter int W_COL = 10,
    parameter int W_ROW = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   en,
    input  logic [W_CHN-1:0]       chn_max,
    input  logic [W_COL-1:0]       col_max,
    input  logic [W_ROW-1:0]       row_max,
    input  logic [MAX_UP_LOG2-1:0] rep_mask,
    output logic                   chn_last,
    output logic                   col_last,
    output logic                   row_last,
    output logic                   col_rep_last,
    output logic                   row_rep_last,
    output logic                   all_last
);

    logic [W_CHN-1:0] chn_q, chn_d;
    logic [W_COL-1:0] col_q, col_d;
    logic [W_ROW-1:0] row_q, row_d;

    assign chn_last     = (chn_q == chn_max);
    assign col_last     = (col_q == col_max);
    assign row_last     = (row_q == row_max);
    // Low bits all-ones mark the last replica of an input pixel / input row.
    assign col_rep_last = ((col_q[MAX_UP_LOG2-1:0] & rep_mask) == rep_mask);
    assign row_rep_last = ((row_q[MAX_UP_LOG2-1:0] & rep_mask) == rep_mask);
    assign all_last     = chn_last && col_last && row_last;

    always_comb begin
        chn_d = chn_q;
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            chn_d = '0;
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (!chn_last) begin
                chn_d = chn_q + W_CHN'(1);
            end else begin
                chn_d = '0;
                if (!col_last) begin
                    col_d = col_q + W_COL'(1);
                end else begin
                    col_d = '0;
                    row_d = row_last ? '0 : row_q + W_ROW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chn_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            chn_q <= chn_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/fm_remap_sequencer.sv
// Upsample / route address sequencer feeding FM-buffer read and write ports.
//  state    | meaning
//  ST_IDLE  | waiting for q_start, config not yet latched
//  ST_RUN   | issuing reads, one address per accepted handshake
//  ST_FLUSH | last read accepted, its paired write is on the bus
//  ST_DONE  | one-cycle done pulse, then back to idle
module fm_remap_sequencer
    import fm_remap_sequencer_pkg::*;
#(
    parameter int W_SIZE    = 8,
    parameter int W_CHANNEL = 8,
    parameter int FM_AW     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel,
    input  logic [W_CHANNEL-1:0] q_channel_out,
    input  logic [W_CHANNEL-1:0] q_chn_offset,
    input  logic [FM_AW-1:0]     q_wr_base,
    input  logic                 q_mode,
    input  logic [1:0]           q_up_log2,
    input  logic                 q_start,
    input  logic                 q_abort,
    fm_remap_sequencer_if.master as
);

    localparam int W_COL = W_SIZE + MAX_UP_LOG2;

    state_e                 state_q, state_d;
    logic [W_CHANNEL-1:0]   chn_max_q, chn_max_d;
    logic [W_COL-1:0]       col_max_q, col_max_d;
    logic [W_COL-1:0]       row_max_q, row_max_d;
    logic [MAX_UP_LOG2-1:0] rep_mask_q, rep_mask_d;
    logic [FM_AW-1:0]       rd_rewind_q, rd_rewind_d;
    logic [FM_AW-1:0]       wr_step_q, wr_step_d;
    logic [FM_AW-1:0]       rd_addr_q, rd_addr_d;
    logic [FM_AW-1:0]       row_base_q, row_base_d;
    logic [FM_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [FM_AW-1:0]       wr_addr_q, wr_addr_d;
    logic                   wr_vld_q, wr_vld_d;

    logic       rd_vld, run_hs, start_ok, zero_size;
    logic [1:0] up_eff;
    logic       chn_last, col_last, row_last, col_rep_last, row_rep_last, all_last;

    assign rd_vld    = (state_q == ST_RUN);
    assign run_hs    = rd_vld && as.rd_rdy && !q_abort;
    assign start_ok  = (state_q == ST_IDLE) && q_start && !q_abort;
    assign zero_size = (q_width == '0) || (q_height == '0) || (q_channel == '0);
    assign up_eff    = eff_up_log2(q_mode, q_up_log2);

    fm_nested_counter #(
        .W_CHN (W_CHANNEL),
        .W_COL (W_COL),
        .W_ROW (W_COL)
    ) u_cnt (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (start_ok),
        .en           (run_hs),
        .chn_max      (chn_max_q),
        .col_max      (col_max_q),
        .row_max      (row_max_q),
        .rep_mask     (rep_mask_q),
        .chn_last     (chn_last),
        .col_last     (col_last),
        .row_last     (row_last),
        .col_rep_last (col_rep_last),
        .row_rep_last (row_rep_last),
        .all_last     (all_last)
    );

    always_comb begin
        state_d     = state_q;
        chn_max_d   = chn_max_q;
        col_max_d   = col_max_q;
        row_max_d   = row_max_q;
        rep_mask_d  = rep_mask_q;
        rd_rewind_d = rd_rewind_q;
        wr_step_d   = wr_step_q;
        rd_addr_d   = rd_addr_q;
        row_base_d  = row_base_q;
        wr_ptr_d    = wr_ptr_q;
        wr_addr_d   = wr_addr_q;
        wr_vld_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    chn_max_d   = q_channel - W_CHANNEL'(1);
                    col_max_d   = (W_COL'(q_width) << up_eff) - W_COL'(1);
                    row_max_d   = (W_COL'(q_height) << up_eff) - W_COL'(1);
                    rep_mask_d  = MAX_UP_LOG2'((1 << up_eff) - 1);
                    rd_rewind_d = FM_AW'(q_channel) - FM_AW'(1);
                    wr_step_d   = FM_AW'(q_channel_out) - FM_AW'(q_channel) + FM_AW'(1);
                    rd_addr_d   = '0;
                    row_base_d  = '0;
                    wr_ptr_d    = q_wr_base + FM_AW'(q_chn_offset);
                    state_d     = zero_size ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (q_abort) begin
                    state_d = ST_IDLE;
                end else if (run_hs) begin
                    wr_vld_d  = 1'b1;
                    wr_addr_d = wr_ptr_q;
                    if (!chn_last) begin
                        rd_addr_d = rd_addr_q + FM_AW'(1);
                        wr_ptr_d  = wr_ptr_q + FM_AW'(1);
                    end else begin
                        wr_ptr_d = wr_ptr_q + wr_step_q;
                        if (!col_last) begin
                            // Repeat the same input pixel until its last replica column.
                            rd_addr_d = col_rep_last ? rd_addr_q + FM_AW'(1)
                                                     : rd_addr_q - rd_rewind_q;
                        end else if (row_rep_last) begin
                            rd_addr_d  = rd_addr_q + FM_AW'(1);
                            row_base_d = rd_addr_q + FM_AW'(1);
                        end else begin
                            rd_addr_d = row_base_q;
                        end
                    end
                    if (all_last) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = q_abort ? ST_IDLE : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            chn_max_q   <= '0;
            col_max_q   <= '0;
            row_max_q   <= '0;
            rep_mask_q  <= '0;
            rd_rewind_q <= '0;
            wr_step_q   <= '0;
            rd_addr_q   <= '0;
            row_base_q  <= '0;
            wr_ptr_q    <= '0;
            wr_addr_q   <= '0;
            wr_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            chn_max_q   <= chn_max_d;
            col_max_q   <= col_max_d;
            row_max_q   <= row_max_d;
            rep_mask_q  <= rep_mask_d;
            rd_rewind_q <= rd_rewind_d;
            wr_step_q   <= wr_step_d;
            rd_addr_q   <= rd_addr_d;
            row_base_q  <= row_base_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_addr_q   <= wr_addr_d;
            wr_vld_q    <= wr_vld_d;
        end
    end

    assign as.rd_vld  = rd_vld;
    assign as.rd_addr = rd_addr_q;
    assign as.wr_vld  = wr_vld_q;
    assign as.wr_addr = wr_addr_q;
    assign as.busy    = (state_q != ST_IDLE);
    assign as.done    = (state_q == ST_DONE);

endmodule
